// File: rtl/ex_ctrl_pkg.sv
// Shared definitions for the execute-stage hazard controller.
//   ex_ctrl_state_t    : controller state encoding
//   X0_REG             : hard-wired zero register index (never a hazard source)
//   DEFAULT_MC_LATENCY : default EX occupancy of a multi-cycle op
package ex_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1,
        FLUSH   = 2'd2
    } ex_ctrl_state_t;

    localparam logic [4:0] X0_REG             = 5'd0;
    localparam int         DEFAULT_MC_LATENCY = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable.
//   clk    : clock
//   rst_n  : asynchronous active-low reset, clears the count
//   en     : increment request
//   count  : current count, sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage pipeline controller.
// Sequences EX for load-use hazards, fixed-latency multi-cycle ops and
// EX-resolved branches, and drives the pipeline register enables.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   RUN     | normal flow; branch > multi-cycle > load-use evaluated
//   MC_WAIT | multi-cycle op occupying EX; mc_cnt counts down to release
//   FLUSH   | redirect cycle; wrong-path fetch squashed, inputs ignored
//
// Ports:
//   clk, reset (async active-low)
//   ex_*   : EX-stage instruction info and branch resolution
//   id_*   : ID-stage instruction operand usage
//   stall_if/stall_id/hold_ex/bubble_ex/flush_id : pipeline register controls
//   redirect_valid/redirect_target               : registered PC redirect
//   busy        : controller not in RUN
//   stall_count : saturating count of stall_if cycles
module ex_hazard_ctrl
    import ex_ctrl_pkg::*;
#(
    parameter int MC_LATENCY = DEFAULT_MC_LATENCY,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic             ex_mc_op,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic [63:0]      ex_branch_target,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    output logic             stall_if,
    output logic             stall_id,
    output logic             hold_ex,
    output logic             bubble_ex,
    output logic             flush_id,
    output logic             redirect_valid,
    output logic [63:0]      redirect_target,
    output logic             busy,
    output logic [CNT_W-1:0] stall_count
);

    // mc_cnt only ever holds up to MC_LATENCY-1.
    localparam int              MC_W      = (MC_LATENCY > 2) ? $clog2(MC_LATENCY) : 1;
    localparam logic [MC_W-1:0] MC_LOAD   = MC_W'(MC_LATENCY - 1);
    localparam bit              MC_ACTIVE = (MC_LATENCY > 1);

    ex_ctrl_state_t  state_q, state_d;
    logic [MC_W-1:0] mc_cnt_q, mc_cnt_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [63:0]     redirect_target_q, redirect_target_d;

    logic branch_hit;
    logic mc_hit;
    logic load_use_hit;

    logic stall_if_raw, stall_id_raw, hold_ex_raw, bubble_ex_raw, flush_id_raw;

    assign branch_hit = ex_valid && ex_branch_taken;
    assign mc_hit     = MC_ACTIVE && ex_valid && ex_mc_op;

    // A load that is also a multi-cycle op never raises a load-use stall.
    assign load_use_hit = ex_valid && ex_mem_read && !ex_mc_op && (ex_rd != X0_REG) && id_valid &&
                          ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                           (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q           <= RUN;
            mc_cnt_q          <= '0;
            redirect_valid_q  <= 1'b0;
            redirect_target_q <= '0;
        end else begin
            state_q           <= state_d;
            mc_cnt_q          <= mc_cnt_d;
            redirect_valid_q  <= redirect_valid_d;
            redirect_target_q <= redirect_target_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        mc_cnt_d          = mc_cnt_q;
        redirect_valid_d  = 1'b0;
        redirect_target_d = redirect_target_q;
        unique case (state_q)
            RUN: begin
                if (branch_hit) begin
                    state_d           = FLUSH;
                    redirect_valid_d  = 1'b1;
                    redirect_target_d = ex_branch_target;
                end else if (mc_hit) begin
                    state_d  = MC_WAIT;
                    mc_cnt_d = MC_LOAD;
                end
            end
            MC_WAIT: begin
                if (mc_cnt_q > MC_W'(1)) begin
                    mc_cnt_d = mc_cnt_q - 1'b1;
                end else begin
                    state_d  = RUN;
                    mc_cnt_d = '0;
                end
            end
            FLUSH: begin
                state_d = RUN;
            end
            default: begin
                state_d  = RUN;
                mc_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        stall_if_raw  = 1'b0;
        stall_id_raw  = 1'b0;
        hold_ex_raw   = 1'b0;
        bubble_ex_raw = 1'b0;
        flush_id_raw  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (branch_hit) begin
                    flush_id_raw  = 1'b1;
                    bubble_ex_raw = 1'b1;
                end else if (mc_hit) begin
                    stall_if_raw = 1'b1;
                    stall_id_raw = 1'b1;
                    hold_ex_raw  = 1'b1;
                end else if (load_use_hit) begin
                    stall_if_raw  = 1'b1;
                    stall_id_raw  = 1'b1;
                    bubble_ex_raw = 1'b1;
                end
            end
            MC_WAIT: begin
                // The final count is the release cycle: EX_MEM captures the result.
                if (mc_cnt_q > MC_W'(1)) begin
                    stall_if_raw = 1'b1;
                    stall_id_raw = 1'b1;
                    hold_ex_raw  = 1'b1;
                end
            end
            FLUSH: begin
                flush_id_raw  = 1'b1;
                bubble_ex_raw = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Inputs may be live during reset; force every control low while it is asserted.
    assign stall_if  = stall_if_raw  && reset;
    assign stall_id  = stall_id_raw  && reset;
    assign hold_ex   = hold_ex_raw   && reset;
    assign bubble_ex = bubble_ex_raw && reset;
    assign flush_id  = flush_id_raw  && reset;

    assign redirect_valid  = redirect_valid_q;
    assign redirect_target = redirect_target_q;
    assign busy            = (state_q != RUN);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .en    (stall_if),
        .count (stall_count)
    );

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
module tb_ex_hazard_ctrl;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic        rst;
        logic        ev;
        logic        mr;
        logic        mc;
        logic [4:0]  rd;
        logic        br;
        logic [63:0] tgt;
        logic        iv;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
    } stim_t;

    typedef struct packed {
        logic [5:0]       flags;   // stall_if, stall_id, hold_ex, bubble_ex, flush_id, redirect_valid
        logic [63:0]      rt;
        logic             busy;
        logic [CNT_W-1:0] sc;
    } exp_t;

    localparam logic [5:0] F_NONE  = 6'b000000;
    localparam logic [5:0] F_STALL = 6'b110100;
    localparam logic [5:0] F_HOLD  = 6'b111000;
    localparam logic [5:0] F_BR    = 6'b000110;
    localparam logic [5:0] F_FL    = 6'b000111;

    logic             clk;
    logic             reset;
    logic             ex_valid, ex_mem_read, ex_mc_op, ex_branch_taken;
    logic [4:0]       ex_rd;
    logic [63:0]      ex_branch_target;
    logic             id_valid, id_uses_rs1, id_uses_rs2;
    logic [4:0]       id_rs1, id_rs2;
    logic             stall_if, stall_id, hold_ex, bubble_ex, flush_id;
    logic             redirect_valid, busy;
    logic [63:0]      redirect_target;
    logic [CNT_W-1:0] stall_count;

    int errors = 0;
    int checks = 0;
    exp_t sb_q[$];
    logic [CNT_W-1:0] sc_exp = '0;

    ex_hazard_ctrl #(
        .MC_LATENCY (4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .ex_valid         (ex_valid),
        .ex_mem_read      (ex_mem_read),
        .ex_mc_op         (ex_mc_op),
        .ex_rd            (ex_rd),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .id_valid         (id_valid),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_uses_rs1      (id_uses_rs1),
        .id_uses_rs2      (id_uses_rs2),
        .stall_if         (stall_if),
        .stall_id         (stall_id),
        .hold_ex          (hold_ex),
        .bubble_ex        (bubble_ex),
        .flush_id         (flush_id),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .busy             (busy),
        .stall_count      (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic stim_t idle_s();
        stim_t s;
        s = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic stim_t lu_s(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic u1, input logic u2);
        stim_t s;
        s = idle_s();
        s.ev = 1'b1; s.mr = 1'b1; s.rd = rd;
        s.iv = 1'b1; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2;
        return s;
    endfunction

    function automatic stim_t mc_s();
        stim_t s;
        s = idle_s();
        s.ev = 1'b1; s.mc = 1'b1; s.mr = 1'b1; s.rd = 5'd5;
        s.iv = 1'b1; s.rs2 = 5'd5; s.u2 = 1'b1;
        return s;
    endfunction

    function automatic stim_t br_on(input stim_t b, input logic [63:0] tgt);
        stim_t s;
        s = b;
        s.ev = 1'b1; s.br = 1'b1; s.tgt = tgt;
        return s;
    endfunction

    // One clock: drive after the rising edge, score on the falling edge.
    task automatic cyc(input string tag, input stim_t s, input logic [5:0] fl,
                       input logic [63:0] rt, input logic bsy);
        exp_t e, o;
        reset            = s.rst;
        ex_valid         = s.ev;
        ex_mem_read      = s.mr;
        ex_mc_op         = s.mc;
        ex_rd            = s.rd;
        ex_branch_taken  = s.br;
        ex_branch_target = s.tgt;
        id_valid         = s.iv;
        id_rs1           = s.rs1;
        id_rs2           = s.rs2;
        id_uses_rs1      = s.u1;
        id_uses_rs2      = s.u2;
        if (!s.rst) sc_exp = '0;
        e.flags = fl;
        e.rt    = rt;
        e.busy  = bsy;
        e.sc    = sc_exp;
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check_eq({tag, "/sb_empty"}, 64'd1, 64'd0);
        end else begin
            o = sb_q.pop_front();
            check_eq({tag, "/stall_if"},  {63'd0, stall_if},  {63'd0, o.flags[5]});
            check_eq({tag, "/stall_id"},  {63'd0, stall_id},  {63'd0, o.flags[4]});
            check_eq({tag, "/hold_ex"},   {63'd0, hold_ex},   {63'd0, o.flags[3]});
            check_eq({tag, "/bubble_ex"}, {63'd0, bubble_ex}, {63'd0, o.flags[2]});
            check_eq({tag, "/flush_id"},  {63'd0, flush_id},  {63'd0, o.flags[1]});
            check_eq({tag, "/redir_v"},   {63'd0, redirect_valid}, {63'd0, o.flags[0]});
            check_eq({tag, "/redir_t"},   redirect_target, o.rt);
            check_eq({tag, "/busy"},      {63'd0, busy},      {63'd0, o.busy});
            check_eq({tag, "/stall_cnt"}, 64'(stall_count),   64'(o.sc));
            if (s.rst && o.flags[5] && (sc_exp != {CNT_W{1'b1}})) sc_exp = sc_exp + 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        stim_t s;
        reset = 1'b0;
        ex_valid = 0; ex_mem_read = 0; ex_mc_op = 0; ex_rd = '0;
        ex_branch_taken = 0; ex_branch_target = '0;
        id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        #1;

        // In reset with live branch + load-use inputs: everything low.
        s = br_on(lu_s(5'd5, 5'd0, 5'd5, 1'b0, 1'b1), 64'h1234);
        s.rst = 1'b0;
        cyc("rst", s, F_NONE, 64'h0, 1'b0);
        cyc("rst_rel", idle_s(), F_NONE, 64'h0, 1'b0);

        // Load-use on rs2, then quiet.
        cyc("lu_rs2", lu_s(5'd5, 5'd0, 5'd5, 1'b0, 1'b1), F_STALL, 64'h0, 1'b0);
        cyc("lu_after", idle_s(), F_NONE, 64'h0, 1'b0);
        cyc("x0", lu_s(5'd0, 5'd0, 5'd0, 1'b1, 1'b1), F_NONE, 64'h0, 1'b0);
        cyc("rs1_unused", lu_s(5'd7, 5'd7, 5'd0, 1'b0, 1'b0), F_NONE, 64'h0, 1'b0);
        cyc("lu_rs1", lu_s(5'd7, 5'd7, 5'd0, 1'b1, 1'b0), F_STALL, 64'h0, 1'b0);
        s = lu_s(5'd7, 5'd7, 5'd0, 1'b1, 1'b0);
        s.iv = 1'b0;
        cyc("id_invalid", s, F_NONE, 64'h0, 1'b0);

        // Multi-cycle (also a load with matching consumer), branch ignored in MC_WAIT.
        cyc("mc0", mc_s(), F_HOLD, 64'h0, 1'b0);
        cyc("mc1", idle_s(), F_HOLD, 64'h0, 1'b1);
        cyc("mc2_br", br_on(idle_s(), 64'hdead), F_HOLD, 64'h0, 1'b1);
        cyc("mc3_rel", idle_s(), F_NONE, 64'h0, 1'b1);
        cyc("mc_done", idle_s(), F_NONE, 64'h0, 1'b0);

        // Branch beats a concurrent load-use; FLUSH ignores a new branch/hazard.
        cyc("br0", br_on(lu_s(5'd5, 5'd0, 5'd5, 1'b0, 1'b1), 64'h1000), F_BR, 64'h0, 1'b0);
        cyc("br1_flush", br_on(lu_s(5'd5, 5'd5, 5'd0, 1'b1, 1'b0), 64'h2000), F_FL, 64'h1000, 1'b1);
        cyc("br2_idle", idle_s(), F_NONE, 64'h1000, 1'b0);

        // Reset asserted while MC_WAIT has mc_cnt==2.
        cyc("mcr0", mc_s(), F_HOLD, 64'h1000, 1'b0);
        cyc("mcr1", idle_s(), F_HOLD, 64'h1000, 1'b1);
        s = mc_s();
        s.rst = 1'b0;
        cyc("mcr_rst", s, F_NONE, 64'h0, 1'b0);
        cyc("mcr_rel", idle_s(), F_NONE, 64'h0, 1'b0);
        cyc("mcn0", mc_s(), F_HOLD, 64'h0, 1'b0);
        cyc("mcn1", idle_s(), F_HOLD, 64'h0, 1'b1);
        cyc("mcn2", idle_s(), F_HOLD, 64'h0, 1'b1);
        cyc("mcn3", idle_s(), F_NONE, 64'h0, 1'b1);
        cyc("mcn_done", idle_s(), F_NONE, 64'h0, 1'b0);

        // Back-to-back load-use stalls drive the counter into saturation.
        for (int i = 0; i < 16; i++) begin
            cyc("sat", lu_s(5'd9, 5'd9, 5'd0, 1'b1, 1'b0), F_STALL, 64'h0, 1'b0);
        end
        cyc("sat_hold", idle_s(), F_NONE, 64'h0, 1'b0);
        check_eq("sat_value", 64'(stall_count), 64'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
